// File: rtl/stopwatch_if.sv
// -----------------------------------------------------------------------------
// stopwatch_if
//   Key and display bundle between the stopwatch controller and its
//   environment (key debouncers on one side, Bin2BCD -> Seg_Ctrl on the other).
//
//   key_ss          start/stop key, debounced level, active-high
//   key_clr         clear/lap-release key, debounced level, active-high
//   key_lap         lap key, debounced level, active-high
//   display_val_bin 20-bit binary value to display
//   running         high while the stopwatch is counting (RUN or LAP)
//   lap_active      high while a lap value is frozen on the display
//   ovf             sticky: live count wrapped since the last clear
//
//   master : key source / display consumer
//   slave  : stopwatch_ctrl
// -----------------------------------------------------------------------------
interface stopwatch_if;
   logic        key_ss;
   logic        key_clr;
   logic        key_lap;
   logic [19:0] display_val_bin;
   logic        running;
   logic        lap_active;
   logic        ovf;

   modport master (
      output key_ss, key_clr, key_lap,
      input  display_val_bin, running, lap_active, ovf
   );

   modport slave (
      input  key_ss, key_clr, key_lap,
      output display_val_bin, running, lap_active, ovf
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/lap/clear controller for the 6-digit stopwatch display path.
//   Edge-detects three debounced keys, sequences IDLE/RUN/LAP/PAUSE, owns the
//   0.01 s prescaler and the live hundredths counter, and drives the binary
//   value that feeds Bin2BCD -> Seg_Ctrl.
//
//   Parameters
//     CNT_MAX  prescaler terminal count (tick every CNT_MAX+1 clocks)
//     VAL_MAX  last displayable count; the following tick wraps to 0
//
//   Ports
//     sys_clk  system clock, rising edge
//     rst_n    asynchronous active-low reset
//     sw       stopwatch_if.slave: keys in, display/status out
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter logic [24:0] CNT_MAX = 25'd499_999,
   parameter logic [19:0] VAL_MAX = 20'd999_999
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   stopwatch_if.slave sw
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t      state_q,   state_d;
   logic        prev_ss_q,  prev_ss_d;
   logic        prev_clr_q, prev_clr_d;
   logic        prev_lap_q, prev_lap_d;
   logic [24:0] presc_q,   presc_d;
   logic [19:0] live_q,    live_d;
   logic [19:0] lap_q,     lap_d;
   logic        ovf_q,     ovf_d;

   logic press_ss;
   logic press_clr;
   logic press_lap;
   logic counting;
   logic tick;

   // Key-edge detection: prev_* reset to 1 so a key already held when reset
   // releases must first be seen low before it can register a press.
   assign press_ss  = sw.key_ss  & ~prev_ss_q;
   assign press_clr = sw.key_clr & ~prev_clr_q;
   assign press_lap = sw.key_lap & ~prev_lap_q;

   // Counting is decided by the pre-edge state, so the edge that enters RUN
   // does not advance the prescaler and the edge that leaves RUN still does.
   // This keeps pause/resume free of partial-tick loss or gain.
   assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign tick     = counting && (presc_q == CNT_MAX);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      presc_d    = presc_q;
      live_d     = live_q;
      lap_d      = lap_q;
      ovf_d      = ovf_q;
      prev_ss_d  = sw.key_ss;
      prev_clr_d = sw.key_clr;
      prev_lap_d = sw.key_lap;

      // Time base
      if (counting) begin
         if (tick) begin
            presc_d = '0;
            if (live_q == VAL_MAX) begin
               live_d = '0;
               ovf_d  = 1'b1;
            end else begin
               live_d = live_q + 20'd1;
            end
         end else begin
            presc_d = presc_q + 25'd1;
         end
      end

      // Key handling: within each state the branches are ordered clr > ss > lap
      // and only presses valid in that state appear, so the highest-priority
      // valid press wins and the rest of the cycle's presses are discarded.
      unique case (state_q)
         ST_IDLE: begin
            if (press_ss) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (press_ss) begin
               state_d = ST_PAUSE;
            end else if (press_lap) begin
               state_d = ST_LAP;
               lap_d   = live_q;   // pre-edge value, even if a tick lands here
            end
         end
         ST_LAP: begin
            if (press_clr) begin
               state_d = ST_RUN;
            end else if (press_ss) begin
               state_d = ST_PAUSE;
            end else if (press_lap) begin
               lap_d = live_q;
            end
         end
         ST_PAUSE: begin
            if (press_clr) begin
               state_d = ST_IDLE;
               presc_d = '0;
               live_d  = '0;
               ovf_d   = 1'b0;
            end else if (press_ss) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         prev_ss_q  <= 1'b1;
         prev_clr_q <= 1'b1;
         prev_lap_q <= 1'b1;
         presc_q    <= '0;
         live_q     <= '0;
         lap_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_ss_q  <= prev_ss_d;
         prev_clr_q <= prev_clr_d;
         prev_lap_q <= prev_lap_d;
         presc_q    <= presc_d;
         live_q     <= live_d;
         lap_q      <= lap_d;
         ovf_q      <= ovf_d;
      end
   end

   // Outputs are decoded from registers only.
   assign sw.display_val_bin = (state_q == ST_LAP) ? lap_q : live_q;
   assign sw.running         = counting;
   assign sw.lap_active      = (state_q == ST_LAP);
   assign sw.ovf             = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with CNT_MAX=4, VAL_MAX=20.
//   The reference model keeps only the number of counted clocks since the last
//   clear; live value and overflow are derived from it arithmetically.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int CNT = 4;
   localparam int VAL = 20;

   // Model modes and keys
   localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
   localparam int K_CLR = 0, K_SS = 1, K_LAP = 2;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;

   stopwatch_if sw ();

   stopwatch_ctrl #(
      .CNT_MAX (25'(CNT)),
      .VAL_MAX (20'(VAL))
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .sw      (sw)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   int   m_mode;
   int   m_elapsed;       // counting clocks since last clear
   logic [19:0] m_lap;
   logic m_prev [3];
   int   next_mode [4][3]; // -1: press ignored in that mode

   function automatic logic [19:0] m_live(input int e);
      return 20'((e / (CNT + 1)) % (VAL + 1));
   endfunction

   function automatic logic [22:0] m_expect();
      logic [19:0] disp;
      disp = (m_mode == M_LAP) ? m_lap : m_live(m_elapsed);
      return {disp, (m_mode == M_RUN || m_mode == M_LAP),
              (m_mode == M_LAP), ((m_elapsed / (CNT + 1)) > VAL)};
   endfunction

   task automatic model_reset();
      m_mode    = M_IDLE;
      m_elapsed = 0;
      m_lap     = '0;
      for (int i = 0; i < 3; i++) m_prev[i] = 1'b1;
   endtask

   task automatic model_edge(input logic ss, clr, lap);
      logic keys [3];
      int   new_el;
      keys[K_CLR] = clr;
      keys[K_SS]  = ss;
      keys[K_LAP] = lap;
      new_el = (m_mode == M_RUN || m_mode == M_LAP) ? m_elapsed + 1 : m_elapsed;
      for (int k = 0; k < 3; k++) begin
         if (keys[k] && !m_prev[k] && next_mode[m_mode][k] >= 0) begin
            if (k == K_LAP) m_lap = m_live(m_elapsed);
            m_mode = next_mode[m_mode][k];
            if (m_mode == M_IDLE) new_el = 0;
            break;
         end
      end
      m_elapsed = new_el;
      for (int k = 0; k < 3; k++) m_prev[k] = keys[k];
   endtask

   // ---------------- helpers ----------------
   function automatic logic [22:0] dut_out();
      return {sw.display_val_bin, sw.running, sw.lap_active, sw.ovf};
   endfunction

   task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got disp=%0d run=%b lap=%b ovf=%b, expected disp=%0d run=%b lap=%b ovf=%b",
                  name, act[22:3], act[2], act[1], act[0], exp[22:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Drive keys away from the edge, clock once, advance the model, sample at +1.
   task automatic apply(input logic ss, clr, lap);
      @(negedge sys_clk);
      sw.key_ss  = ss;
      sw.key_clr = clr;
      sw.key_lap = lap;
      @(posedge sys_clk);
      model_edge(ss, clr, lap);
      #1;
   endtask

   task automatic step(input logic ss, clr, lap, input string name);
      apply(ss, clr, lap);
      check(name, dut_out(), m_expect());
   endtask

   task automatic do_reset(input logic ss_held);
      @(negedge sys_clk);
      sw.key_ss  = ss_held;
      sw.key_clr = 1'b0;
      sw.key_lap = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #3;
      check("reset_state", dut_out(), 23'd0);
      @(negedge sys_clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic        ss, clr, lap;
      logic [19:0] disp;
      logic        run, lapa, ovf;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] frozen;

      foreach (next_mode[i, j]) next_mode[i][j] = -1;
      next_mode[M_IDLE][K_SS]   = M_RUN;
      next_mode[M_RUN][K_SS]    = M_PAUSE;
      next_mode[M_RUN][K_LAP]   = M_LAP;
      next_mode[M_LAP][K_CLR]   = M_RUN;
      next_mode[M_LAP][K_SS]    = M_PAUSE;
      next_mode[M_LAP][K_LAP]   = M_LAP;
      next_mode[M_PAUSE][K_CLR] = M_IDLE;
      next_mode[M_PAUSE][K_SS]  = M_RUN;

      //          ss  clr lap  disp  run lap ovf
      tbl[0]  = '{1'b0,1'b0,1'b0, 20'd0, 1'b0,1'b0,1'b0}; // idle
      tbl[1]  = '{1'b1,1'b0,1'b0, 20'd0, 1'b1,1'b0,1'b0}; // start
      tbl[2]  = '{1'b0,1'b0,1'b0, 20'd0, 1'b1,1'b0,1'b0}; // presc 1
      tbl[3]  = '{1'b0,1'b0,1'b0, 20'd0, 1'b1,1'b0,1'b0}; // presc 2
      tbl[4]  = '{1'b0,1'b0,1'b0, 20'd0, 1'b1,1'b0,1'b0}; // presc 3
      tbl[5]  = '{1'b0,1'b0,1'b0, 20'd0, 1'b1,1'b0,1'b0}; // presc 4
      tbl[6]  = '{1'b0,1'b0,1'b0, 20'd1, 1'b1,1'b0,1'b0}; // first tick
      tbl[7]  = '{1'b0,1'b0,1'b1, 20'd1, 1'b1,1'b1,1'b0}; // lap captures 1
      tbl[8]  = '{1'b0,1'b0,1'b0, 20'd1, 1'b1,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b1,1'b0, 20'd1, 1'b1,1'b0,1'b0}; // clr releases lap
      tbl[10] = '{1'b0,1'b0,1'b0, 20'd1, 1'b1,1'b0,1'b0}; // presc 4
      tbl[11] = '{1'b1,1'b1,1'b0, 20'd2, 1'b0,1'b0,1'b0}; // clr+ss in RUN: pause, tick
      tbl[12] = '{1'b0,1'b0,1'b0, 20'd2, 1'b0,1'b0,1'b0};
      tbl[13] = '{1'b1,1'b1,1'b0, 20'd0, 1'b0,1'b0,1'b0}; // clr+ss in PAUSE: idle
      tbl[14] = '{1'b0,1'b0,1'b0, 20'd0, 1'b0,1'b0,1'b0};

      sw.key_ss = 1'b0; sw.key_clr = 1'b0; sw.key_lap = 1'b0;
      do_reset(1'b0);

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].ss, tbl[i].clr, tbl[i].lap);
         check($sformatf("table[%0d]", i), dut_out(),
               {tbl[i].disp, tbl[i].run, tbl[i].lapa, tbl[i].ovf});
      end

      // Pause at prescaler 2, hold, resume: next increment exactly 2 clocks later.
      do_reset(1'b0);
      step(0, 0, 0, "pr_idle");
      step(1, 0, 0, "pr_start");
      step(0, 0, 0, "pr_p1");
      step(0, 0, 0, "pr_p2");
      step(1, 0, 0, "pr_pause");
      frozen = sw.display_val_bin;
      for (int i = 0; i < 50; i++) step(0, 0, 0, "pr_hold");
      check("pr_frozen", {sw.display_val_bin, sw.running, 2'b00}, {frozen, 1'b0, 2'b00});
      step(1, 0, 0, "pr_resume");
      step(0, 0, 0, "pr_r1");
      check("pr_r1_const", dut_out(), {20'd0, 1'b1, 1'b0, 1'b0});
      step(0, 0, 0, "pr_r2");
      check("pr_r2_const", dut_out(), {20'd1, 1'b1, 1'b0, 1'b0});

      // Count through VAL_MAX: wrap to 0 with ovf, then pause + clear.
      do_reset(1'b0);
      step(0, 0, 0, "wr_idle");
      step(1, 0, 0, "wr_start");
      for (int i = 0; i < (VAL + 1) * (CNT + 1); i++) step(0, 0, 0, "wr_run");
      check("wr_wrapped", dut_out(), {20'd0, 1'b1, 1'b0, 1'b1});
      step(1, 0, 0, "wr_pause");
      step(0, 0, 0, "wr_gap");
      step(0, 1, 0, "wr_clear");
      check("wr_cleared", dut_out(), 23'd0);

      // key_ss held across reset release: no start.
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, "hold_rst");
      check("hold_rst_idle", dut_out(), 23'd0);

      // key_ss held 100 clocks in RUN: exactly one RUN->PAUSE.
      step(0, 0, 0, "hold_low");
      step(1, 0, 0, "hold_start");
      step(0, 0, 0, "hold_gap");
      for (int i = 0; i < 100; i++) step(1, 0, 0, "hold_ss");
      check("hold_paused", {sw.running, sw.lap_active}, {1'b0, 1'b0} );

      // Async reset mid-LAP.
      step(0, 0, 0, "ar_rel");
      step(1, 0, 0, "ar_resume");
      for (int i = 0; i < 12; i++) step(0, 0, 0, "ar_run");
      step(0, 0, 1, "ar_lap");
      check("ar_in_lap", {sw.running, sw.lap_active}, {1'b1, 1'b1});
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("ar_async_zero", dut_out(), 23'd0);
      @(negedge sys_clk);
      rst_n = 1'b1;

      // Randomized keys against the model.
      begin
         logic ks, kc, kl;
         ks = 1'b0; kc = 1'b0; kl = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) ks = ~ks;
            if ($urandom_range(0, 11) == 0) kc = ~kc;
            if ($urandom_range(0, 6) == 0) kl = ~kl;
            step(ks, kc, kl, "random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
